// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state and ALU control encodings for the multicycle MIPS core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR) || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// Shared integer ALU: add/sub/and/or/signed slt, wrapping at W bits; zero flag for branch compare.
// Latency: combinational. Backpressure: none.
// Ports: ctrl (operation), a/b (operands), y (result), zero (y == 0).
module alu
  import mips_pkg::*;
#(
  parameter int W = 32
) (
  input  alu_ctrl_t    ctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         zero
);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mips_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, register 0 reads as zero.
// Latency: reads combinational, write visible after the clock edge. Backpressure: none.
// Ports: clk/reset (sync, clears all), ra_a/ra_b -> rd_a/rd_b, we/wa/wd write port.
module mips_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int RW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RW-1:0]     ra_a,
  input  logic [RW-1:0]     ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              we,
  input  logic [RW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = (ra_a == '0) ? '0 : regs[ra_a];
  assign rd_b = (ra_b == '0) ? '0 : regs[ra_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core (R add/sub/and/or/slt, addi, lw, sw, beq, j) over one shared memory port.
// Latency: beq/j 3, R/addi/sw 4, lw 5 cycles with zero-wait memory; +1 per memory wait cycle.
// Backpressure: mem_req/we/addr/wdata held until mem_ready; halts on illegal opcode/funct or misaligned data.
// Ports: clk, reset (sync, active-high); mem_* request port; halt, retire pulse, pc_out.
// Optional MIPS_MC_PERF_CNT_EN adds cycle_cnt (non-halted cycles) and instr_cnt (retired instructions).
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                NREGS    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halt,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_out
`ifdef MIPS_MC_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instr_cnt
`endif
);

  localparam int RW = $clog2(NREGS);
  // Low 28 bits replaced by a jump; upper PC bits are kept.
  localparam logic [ADDR_W-1:0] JMASK = ADDR_W'((64'd1 << 28) - 64'd1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, br_target;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_out, mdr;
  logic [DATA_W-1:0] rf_rd_a, rf_rd_b, rf_wd, alu_b, alu_y, sext_imm;
  logic [ADDR_W-1:0] br_off, jt;
  logic [RW-1:0]     rf_wa;
  logic              rf_we, alu_zero;
  alu_ctrl_t         alu_ctrl;

  wire  [5:0]  opcode = ir[31:26];
  wire  [5:0]  funct  = ir[5:0];
  wire  [15:0] imm16  = ir[15:0];
  wire  [27:0] j28    = {ir[25:0], 2'b00};
  logic        unused_shamt;
  assign unused_shamt = ^ir[10:6];

  assign sext_imm = {{(DATA_W-16){imm16[15]}}, imm16};
  assign br_off   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  // pc already holds PC+4 in DECODE, which is the base for both targets.
  assign jt       = (pc & ~JMASK) | (ADDR_W'(j28) & JMASK);

  mips_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RW(RW)) u_rf (
    .clk  (clk),
    .reset(reset),
    .ra_a (ir[21 +: RW]),
    .ra_b (ir[16 +: RW]),
    .rd_a (rf_rd_a),
    .rd_b (rf_rd_b),
    .we   (rf_we),
    .wa   (rf_wa),
    .wd   (rf_wd)
  );

  // One ALU serves R-type ops, immediate/address adds and the beq compare (SUB + zero).
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_b    = sext_imm;
    if (opcode == OP_R) begin
      alu_b = b_q;
      case (funct)
        FN_SUB:  alu_ctrl = ALU_SUB;
        FN_AND:  alu_ctrl = ALU_AND;
        FN_OR:   alu_ctrl = ALU_OR;
        FN_SLT:  alu_ctrl = ALU_SLT;
        default: alu_ctrl = ALU_ADD;
      endcase
    end else if (opcode == OP_BEQ) begin
      alu_b    = b_q;
      alu_ctrl = ALU_SUB;
    end
  end

  alu #(.W(DATA_W)) u_alu (
    .ctrl(alu_ctrl),
    .a   (a_q),
    .b   (alu_b),
    .y   (alu_y),
    .zero(alu_zero)
  );

  assign rf_wa     = (opcode == OP_R) ? ir[11 +: RW] : ir[16 +: RW];
  assign rf_wd     = (opcode == OP_LW) ? mdr : alu_out;
  assign mem_addr  = (state == ST_FETCH) ? pc : ADDR_W'(alu_out);
  assign mem_wdata = b_q;
  assign halt      = (state == ST_HALT);
  assign pc_out    = pc;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nx;
  end

  // Requests are masked while reset is held so an aborted access drops immediately.
  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    retire   = 1'b0;
    rf_we    = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = !reset;
        if (mem_ready) state_nx = ST_DECODE;
      end
      ST_DECODE: state_nx = opcode_legal(opcode) ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        case (opcode)
          OP_R:         state_nx = funct_legal(funct) ? ST_WB : ST_HALT;
          OP_ADDI:      state_nx = ST_WB;
          OP_LW, OP_SW: state_nx = (alu_y[1:0] != 2'b00) ? ST_HALT : ST_MEM;
          OP_BEQ, OP_J: begin
            retire   = 1'b1;
            state_nx = ST_FETCH;
          end
          default:      state_nx = ST_HALT;
        endcase
      end
      ST_MEM: begin
        mem_req = !reset;
        mem_we  = !reset && (opcode == OP_SW);
        if (mem_ready) begin
          retire   = (opcode == OP_SW);
          state_nx = (opcode == OP_SW) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        rf_we    = 1'b1;
        retire   = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      br_target <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
    end else begin
      case (state)
        ST_FETCH: if (mem_ready) begin
          ir <= mem_rdata[31:0];
          pc <= pc + ADDR_W'(4);
        end
        ST_DECODE: begin
          a_q       <= rf_rd_a;
          b_q       <= rf_rd_b;
          br_target <= (opcode == OP_J) ? jt : pc + br_off;
        end
        ST_EXEC: begin
          alu_out <= alu_y;
          if ((opcode == OP_J) || ((opcode == OP_BEQ) && alu_zero)) pc <= br_target;
        end
        ST_MEM: if (mem_ready && (opcode == OP_LW)) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != ST_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)           instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a word-addressed memory model.
// Latency: n/a. Backpressure: model inserts wait_cfg wait cycles per request and can stall stores.
module tb_mips_multicycle_core;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halt, retire;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int tests = 0;
  int fails = 0;

  int          wait_cfg = 0;
  int          wcnt = 0;
  bit          block_store = 1'b0;
  bit          clr_dmem = 1'b1;
  logic [31:0] prog [1024];
  logic [31:0] dmem [1024];
  logic [1023:0] dvalid;

  mips_multicycle_core #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'h0), .NREGS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .halt     (halt),
    .retire   (retire),
    .pc_out   (pc_out)
`ifdef MIPS_MC_PERF_CNT_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Ready is also raised while idle; the core must ignore it then.
  assign mem_ready = mem_req ? ((wcnt >= wait_cfg) && !(block_store && mem_we)) : 1'b1;
  assign mem_rdata = dvalid[mem_addr[11:2]] ? dmem[mem_addr[11:2]] : prog[mem_addr[11:2]];

  always @(posedge clk) begin
    if (!mem_req || mem_ready) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
    if (clr_dmem) dvalid <= '0;
    else if (mem_req && mem_we && mem_ready) begin
      dmem[mem_addr[11:2]]   <= mem_wdata;
      dvalid[mem_addr[11:2]] <= 1'b1;
    end
  end

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return dvalid[a[11:2]] ? dmem[a[11:2]] : prog[a[11:2]];
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_R, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = 32'hDEADBEEF;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    prog[a[11:2]] = w;
  endtask

  // Returns in the first cycle with reset still held after a reset edge.
  task automatic reset_on();
    @(negedge clk);
    reset    = 1'b1;
    clr_dmem = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_off();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    clr_dmem = 1'b0;
  endtask

  task automatic wait_fetch(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == a) ok = 1'b1;
    end
  endtask

  task automatic wait_store(output logic [31:0] a, output logic [31:0] d, output bit ok);
    ok = 1'b0; a = '0; d = '0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (mem_req && mem_we && mem_ready) begin
        ok = 1'b1; a = mem_addr; d = mem_wdata;
      end
    end
  endtask

  task automatic wait_retire(output int n, output bit ok);
    ok = 1'b0; n = 0;
    for (int i = 1; i <= 100 && !ok; i++) begin
      @(negedge clk);
      if (retire) begin ok = 1'b1; n = i; end
    end
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (halt) ok = 1'b1;
    end
  endtask

  initial begin
    logic [11:0] rv;
    logic [7:0]  reqv;
    logic [31:0] sa, sd;
    bit          ok;
    int          n;
    logic        any_req;

    // ---- ALU ops, $0 handling, retire cadence, zero-wait memory
    clear_prog();
    put(0,  enc_i(OP_ADDI, 0, 1, 16'd5));
    put(4,  enc_i(OP_ADDI, 0, 2, 16'd7));
    put(8,  enc_r(1, 2, 3, FN_ADD));
    put(12, enc_i(OP_SW, 0, 3, 16'h0080));
    put(16, enc_i(OP_ADDI, 0, 0, 16'd9));
    put(20, enc_r(0, 0, 5, FN_ADD));
    put(24, enc_i(OP_SW, 0, 5, 16'h0084));
    put(28, enc_i(OP_ADDI, 0, 6, 16'hFFFF));
    put(32, enc_i(OP_ADDI, 0, 7, 16'd1));
    put(36, enc_r(6, 7, 8, FN_SLT));
    put(40, enc_i(OP_SW, 0, 8, 16'h0088));
    put(44, enc_r(7, 6, 9, FN_SLT));
    put(48, enc_r(1, 2, 10, FN_SUB));
    put(52, enc_r(1, 2, 11, FN_AND));
    put(56, enc_r(1, 2, 12, FN_OR));
    put(60, enc_i(OP_SW, 0, 9,  16'h008C));
    put(64, enc_i(OP_SW, 0, 10, 16'h0090));
    put(68, enc_i(OP_SW, 0, 11, 16'h0094));
    put(72, enc_i(OP_SW, 0, 12, 16'h0098));
    wait_cfg = 0;
    reset_on();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",  {31'd0, mem_we},  32'd0);
    check("rst_halt",    {31'd0, halt},    32'd0);
    check("rst_retire",  {31'd0, retire},  32'd0);
    check("rst_pc",      pc_out,           32'h0);
    reset_off();
    rv = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rv[c-1] = retire;
      if (c == 1) begin
        check("first_req",  {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr,         32'h0);
      end
    end
    check("retire_cycles_4_8_12", {20'd0, rv}, 32'h888);
`ifdef MIPS_MC_PERF_CNT_EN
    check("cycle_cnt_c12", cycle_cnt, 32'd11);
    check("instr_cnt_c12", instr_cnt, 32'd2);
`endif
    wait_store(sa, sd, ok);
    check("sw3_seen", {31'd0, ok}, 32'd1);
    check("sw3_addr", sa, 32'h80);
    check("sw3_data", sd, 32'd12);
    wait_halt(ok);
    check("p1_halt", {31'd0, ok}, 32'd1);
    check("r0_discard", rd_word(32'h84), 32'd0);
    check("slt_neg_lt", rd_word(32'h88), 32'd1);
    check("slt_signed", rd_word(32'h8C), 32'd0);
    check("sub_wrap",   rd_word(32'h90), 32'hFFFFFFFE);
    check("and",        rd_word(32'h94), 32'd5);
    check("or",         rd_word(32'h98), 32'd7);

    // ---- sw/lw with one wait cycle per transaction
    reset_on();
    check("halt_cleared", {31'd0, halt}, 32'd0);
    clear_prog();
    put(0,  enc_i(OP_ADDI, 0, 3, 16'd12));
    put(4,  enc_i(OP_SW, 0, 3, 16'h0040));
    put(8,  enc_i(OP_LW, 0, 4, 16'h0040));
    put(12, enc_i(OP_SW, 0, 4, 16'h0044));
    wait_cfg = 1;
    reset_off();
    wait_store(sa, sd, ok);
    check("sw40_seen", {31'd0, ok}, 32'd1);
    check("sw40_addr", sa, 32'h40);
    check("sw40_data", sd, 32'd12);
    wait_retire(n, ok);
    check("lw_retired", {31'd0, ok}, 32'd1);
    check("lw_cycles", n, 32'd7);
    wait_halt(ok);
    check("p2_halt", {31'd0, ok}, 32'd1);
    check("lw_value", rd_word(32'h44), 32'd12);

    // ---- beq taken / not taken, j, illegal opcode
    reset_on();
    clear_prog();
    put(32'h000, enc_i(OP_ADDI, 0, 1, 16'd3));
    put(32'h004, enc_i(OP_ADDI, 0, 0, 16'd0));
    put(32'h008, enc_i(OP_ADDI, 0, 0, 16'd0));
    put(32'h00C, enc_i(OP_ADDI, 0, 0, 16'd0));
    put(32'h010, enc_i(OP_BEQ, 1, 1, 16'd2));
    put(32'h01C, {OP_J, 26'h100});
    put(32'h400, enc_i(OP_BEQ, 1, 0, 16'd5));
    put(32'h404, enc_i(OP_ADDI, 0, 2, 16'h0055));
    put(32'h408, enc_i(OP_SW, 0, 2, 16'h0048));
    put(32'h40C, 32'hFC000000);
    wait_cfg = 0;
    reset_off();
    wait_fetch(32'h10, ok);
    check("beq_fetch_seen", {31'd0, ok}, 32'd1);
    @(negedge clk); @(negedge clk);
    check("beq_retire_c3", {31'd0, retire}, 32'd1);
    @(negedge clk);
    check("beq_target", mem_addr, 32'h1C);
    check("beq_pc",     pc_out,   32'h1C);
    @(negedge clk); @(negedge clk);
    check("j_retire_c3", {31'd0, retire}, 32'd1);
    @(negedge clk);
    check("j_target", mem_addr, 32'h400);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("beq_not_taken", mem_addr, 32'h404);
    wait_fetch(32'h40C, ok);
    check("illegal_fetch_seen", {31'd0, ok}, 32'd1);
    @(negedge clk);
    check("decode_no_halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    check("illegal_halt", {31'd0, halt}, 32'd1);
    any_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      any_req = any_req | mem_req;
      @(negedge clk);
    end
    check("halt_no_req", {31'd0, any_req}, 32'd0);
    check("j_path_store", rd_word(32'h48), 32'h55);

    // ---- misaligned lw halts without a request
    reset_on();
    clear_prog();
    put(0, enc_i(OP_LW, 0, 1, 16'h0041));
    reset_off();
    reqv = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      reqv[c-1] = mem_req;
      if (c == 3) check("misalign_exec_no_halt", {31'd0, halt}, 32'd0);
      if (c == 4) check("misalign_halt", {31'd0, halt}, 32'd1);
    end
    check("misalign_req_pattern", {24'd0, reqv}, 32'h01);

    // ---- reset aborting a stalled store, then refetch from RESET_PC
    reset_on();
    clear_prog();
    put(0, enc_i(OP_ADDI, 0, 1, 16'd1));
    put(4, enc_i(OP_SW, 0, 1, 16'h0050));
    block_store = 1'b1;
    reset_off();
    repeat (12) @(negedge clk);
    check("stall_req",   {31'd0, mem_req}, 32'd1);
    check("stall_we",    {31'd0, mem_we},  32'd1);
    check("stall_addr",  mem_addr,         32'h50);
    check("stall_wdata", mem_wdata,        32'd1);
    check("stall_pc",    pc_out,           32'h8);
    reset_on();
    check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_pc",  pc_out,           32'h0);
`ifdef MIPS_MC_PERF_CNT_EN
    check("abort_cycle_cnt", cycle_cnt, 32'd0);
    check("abort_instr_cnt", instr_cnt, 32'd0);
`endif
    block_store = 1'b0;
    reset_off();
    @(negedge clk);
    check("refetch_req",  {31'd0, mem_req}, 32'd1);
    check("refetch_addr", mem_addr,         32'h0);
    check("refetch_we",   {31'd0, mem_we},  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
